alu_control_md: RTL and testbench

Parametrised second-generation ALU control for the single-cycle MIPS datapath. It decodes ALUOp and the R-type funct field into a 4-bit ALU function, covering the full original encoding plus SLTU and a corrected XOR decode. It adds a sequential multiply/divide engine with HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI and MFLO, and a stall output that freezes the PC and pipeline while the engine is busy.

---
 rtl/alu_md_pkg.sv | 49 ++++
 rtl/alu_control_md_if.sv | 31 +++
 rtl/md_engine.sv | 127 ++++++++++++
 rtl/alu_control_md.sv | 75 +++++++
 tb/tb_alu_control_md.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_md_pkg.sv
// Shared encodings for the MIPS ALU control block: ALUOp codes, funct codes,
// ALU function codes and the multiply/divide engine state.
package alu_md_pkg;

  localparam logic [3:0] ALUOP_LSW    = 4'b0000;
  localparam logic [3:0] ALUOP_BRANCH = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE  = 4'b0010;
  localparam logic [3:0] ALUOP_ADDI   = 4'b0100;
  localparam logic [3:0] ALUOP_ADDIU  = 4'b0101;
  localparam logic [3:0] ALUOP_ANDI   = 4'b0110;
  localparam logic [3:0] ALUOP_ORI    = 4'b0111;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    FN_NOP  = 4'b0000,
    FN_ADDU = 4'b0001,
    FN_SUB  = 4'b0010,
    FN_SUBU = 4'b0011,
    FN_AND  = 4'b0100,
    FN_OR   = 4'b0101,
    FN_XOR  = 4'b0110,
    FN_ADD  = 4'b0111,
    FN_SLT  = 4'b1010,
    FN_SLTU = 4'b1011
  } alu_func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/alu_control_md_if.sv
// Instruction-side bus of the ALU control block: decode inputs, operands,
// and the decode, stall and HI/LO results returned to the datapath.
interface alu_control_md_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int FUNCW = 6
) ();
  logic [OPW-1:0]   alu_op;
  logic [FUNCW-1:0] funct;
  logic             valid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       alu_func;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_result;
  logic             mf_valid;
  logic             div_zero;

  modport master (
    output alu_op, funct, valid, op_a, op_b,
    input  alu_func, stall, busy, hi, lo, mf_result, mf_valid, div_zero
  );

  modport slave (
    input  alu_op, funct, valid, op_a, op_b,
    output alu_func, stall, busy, hi, lo, mf_result, mf_valid, div_zero
  );
endinterface

// File: rtl/md_engine.sv
// Sequential multiply/divide engine: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up into HI/LO.
module md_engine
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic               is_div_q, dz_q, neg_res_q, neg_rem_q;
  logic               busy_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mag_a = (is_signed_i && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
    mag_b = (is_signed_i && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;

    // acc_q = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // acc_q = {partial remainder, dividend bits shifting into quotient bits}
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_fits  = div_shift >= {1'b0, mag_b_q};
    div_rem   = div_fits ? (div_shift[WIDTH-1:0] - mag_b_q) : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_fits};

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and clears
  // the datapath too; an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      mag_b_q    <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q    <= 1'b1;
            count_q   <= CW'(WIDTH - 1);
            is_div_q  <= is_div_i;
            dz_q      <= is_div_i && (op_b_i == '0);
            neg_res_q <= is_signed_i && (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
            neg_rem_q <= is_signed_i && op_a_i[WIDTH-1];
            mag_b_q   <= mag_b;
            acc_q     <= {{WIDTH{1'b0}}, mag_a};
            state_q   <= is_div_i ? DIV : MUL;
          end
        end
        MUL: begin
          acc_q <= mul_next;
          if (count_q == '0) state_q <= FIX;
          else               count_q <= count_q - 1'b1;
        end
        DIV: begin
          acc_q <= div_next;
          if (count_q == '0) begin
            state_q    <= FIX;
            div_zero_q <= dz_q;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        FIX: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= dz_q ? '1 : quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: rtl/alu_control_md.sv
// ALU control: combinational ALUOp/funct decode, stall and MFHI/MFLO logic,
// wrapped around the multiply/divide engine.
module alu_control_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int FUNCW = 6
) (
  input  logic             clk,
  input  logic             reset,
  alu_control_md_if.slave  bus
);

  alu_func_e func;
  logic is_rtype, is_md, is_mf, is_mfhi, is_mflo;
  logic is_div, is_signed, md_start;

  always_comb begin
    func = FN_NOP;
    case (bus.alu_op)
      OPW'(ALUOP_LSW), OPW'(ALUOP_ADDI): func = FN_ADD;
      OPW'(ALUOP_ADDIU):                 func = FN_ADDU;
      OPW'(ALUOP_ANDI):                  func = FN_AND;
      OPW'(ALUOP_ORI):                   func = FN_OR;
      OPW'(ALUOP_BRANCH):                func = FN_SUB;
      OPW'(ALUOP_RTYPE): begin
        case (bus.funct)
          FUNCW'(F_ADD):  func = FN_ADD;
          FUNCW'(F_ADDU): func = FN_ADDU;
          FUNCW'(F_AND):  func = FN_AND;
          FUNCW'(F_OR):   func = FN_OR;
          FUNCW'(F_XOR):  func = FN_XOR;
          FUNCW'(F_SLT):  func = FN_SLT;
          FUNCW'(F_SLTU): func = FN_SLTU;
          FUNCW'(F_SUB):  func = FN_SUB;
          FUNCW'(F_SUBU): func = FN_SUBU;
          default:        func = FN_NOP;
        endcase
      end
      default: func = FN_NOP;
    endcase
  end

  assign is_rtype  = bus.alu_op == OPW'(ALUOP_RTYPE);
  assign is_md     = (bus.funct == FUNCW'(F_MULT)) || (bus.funct == FUNCW'(F_MULTU)) ||
                     (bus.funct == FUNCW'(F_DIV))  || (bus.funct == FUNCW'(F_DIVU));
  assign is_div    = (bus.funct == FUNCW'(F_DIV))  || (bus.funct == FUNCW'(F_DIVU));
  assign is_signed = (bus.funct == FUNCW'(F_MULT)) || (bus.funct == FUNCW'(F_DIV));
  assign is_mfhi   = is_rtype && (bus.funct == FUNCW'(F_MFHI));
  assign is_mflo   = is_rtype && (bus.funct == FUNCW'(F_MFLO));
  assign is_mf     = is_mfhi || is_mflo;

  // Only MD and MF instructions wait on the engine; everything else flows on.
  assign md_start     = bus.valid && is_rtype && is_md && !bus.busy;
  assign bus.stall    = bus.valid && is_rtype && (is_md || is_mf) && bus.busy;
  assign bus.mf_valid = bus.valid && is_mf && !bus.busy;
  assign bus.mf_result = is_mfhi ? bus.hi : (is_mflo ? bus.lo : '0);
  assign bus.alu_func = func;

  md_engine #(.WIDTH(WIDTH)) u_md_engine (
    .clk         (clk),
    .reset       (reset),
    .start_i     (md_start),
    .is_div_i    (is_div),
    .is_signed_i (is_signed),
    .op_a_i      (bus.op_a),
    .op_b_i      (bus.op_b),
    .busy_o      (bus.busy),
    .hi_o        (bus.hi),
    .lo_o        (bus.lo),
    .div_zero_o  (bus.div_zero)
  );

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode sweep, multiply/divide results and
// latency, divide-by-zero, MF stall, back-to-back issue and mid-operation reset.
module tb_alu_control_md;
  import alu_md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_control_md_if #(.WIDTH(32), .OPW(4), .FUNCW(6)) bus ();

  alu_control_md #(.WIDTH(32), .OPW(4), .FUNCW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] op;
    logic [5:0] f;
    logic [3:0] exp;
  } dec_vec_t;

  task automatic drive(input logic [3:0] op, input logic [5:0] f, input logic v,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = op;
    bus.funct  = f;
    bus.valid  = v;
    bus.op_a   = a;
    bus.op_b   = b;
  endtask

  // Issue one MD op for a single cycle, then count busy and div_zero cycles.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output int dz_cyc);
    @(negedge clk);
    drive(ALUOP_RTYPE, f, 1'b1, a, b);
    @(negedge clk);
    drive(ALUOP_LSW, 6'd0, 1'b0, 32'd0, 32'd0);
    busy_cyc = 0;
    dz_cyc   = 0;
    while (bus.busy === 1'b1 && busy_cyc < 100) begin
      busy_cyc++;
      if (bus.div_zero === 1'b1) dz_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(ALUOP_LSW, 6'd0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    n_tests++; if (bus.hi !== 32'd0)        begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    n_tests++; if (bus.lo !== 32'd0)        begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    n_tests++; if (bus.div_zero !== 1'b0)   begin n_fail++; $display("FAIL reset_div_zero got %0b want 0", bus.div_zero); end
    n_tests++; if (bus.mf_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_mf_valid got %0b want 0", bus.mf_valid); end
    n_tests++; if (bus.mf_result !== 32'd0) begin n_fail++; $display("FAIL reset_mf_result got %h want 0", bus.mf_result); end
    n_tests++; if (bus.stall !== 1'b0)      begin n_fail++; $display("FAIL reset_stall got %0b want 0", bus.stall); end
  endtask

  task automatic test_decode;
    dec_vec_t vecs[23];
    vecs = '{
      '{4'b0000, 6'b101010, 4'b0111}, '{4'b0100, 6'b101010, 4'b0111},
      '{4'b0101, 6'b101010, 4'b0001}, '{4'b0110, 6'b101010, 4'b0100},
      '{4'b0111, 6'b101010, 4'b0101}, '{4'b0001, 6'b101010, 4'b0010},
      '{4'b0011, 6'b100000, 4'b0000}, '{4'b1000, 6'b100000, 4'b0000},
      '{4'b1111, 6'b100000, 4'b0000},
      '{4'b0010, 6'b100000, 4'b0111}, '{4'b0010, 6'b100001, 4'b0001},
      '{4'b0010, 6'b100100, 4'b0100}, '{4'b0010, 6'b100101, 4'b0101},
      '{4'b0010, 6'b100110, 4'b0110}, '{4'b0010, 6'b101010, 4'b1010},
      '{4'b0010, 6'b101011, 4'b1011}, '{4'b0010, 6'b100010, 4'b0010},
      '{4'b0010, 6'b100011, 4'b0011}, '{4'b0010, 6'b111111, 4'b0000},
      '{4'b0010, 6'b011000, 4'b0000}, '{4'b0010, 6'b011011, 4'b0000},
      '{4'b0010, 6'b010000, 4'b0000}, '{4'b0010, 6'b010010, 4'b0000}
    };
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].f, 1'b0, 32'd0, 32'd0);
      #1;
      n_tests++;
      if (bus.alu_func !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL decode[%0d] op=%b funct=%b got %b want %b",
                 i, vecs[i].op, vecs[i].f, bus.alu_func, vecs[i].exp);
      end
    end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL decode_no_start got busy %0b want 0", bus.busy); end
  endtask

  task automatic test_mult;
    int cyc, dz;
    run_md(F_MULT, 32'hFFFF_FFFD, 32'd7, cyc, dz);
    n_tests++; if (cyc !== 33)              begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 33", cyc); end
    n_tests++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
    n_tests++; if (bus.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", bus.lo); end
    run_md(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, dz);
    n_tests++; if (bus.hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi got %h want fffffffe", bus.hi); end
    n_tests++; if (bus.lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_max_lo got %h want 00000001", bus.lo); end
  endtask

  task automatic test_div;
    int cyc, dz;
    run_md(F_DIV, 32'hFFFF_FFF9, 32'd2, cyc, dz);
    n_tests++; if (cyc !== 33)              begin n_fail++; $display("FAIL div_busy_cycles got %0d want 33", cyc); end
    n_tests++; if (dz !== 0)                begin n_fail++; $display("FAIL div_no_dz got %0d want 0", dz); end
    n_tests++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo got %h want fffffffd", bus.lo); end
    n_tests++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi got %h want ffffffff", bus.hi); end
    run_md(F_DIVU, 32'd100, 32'd7, cyc, dz);
    n_tests++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %h want 0000000e", bus.lo); end
    n_tests++; if (bus.hi !== 32'd2)  begin n_fail++; $display("FAIL divu_hi got %h want 00000002", bus.hi); end
    run_md(F_DIV, 32'd7, 32'hFFFF_FFFE, cyc, dz);
    n_tests++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_lo got %h want fffffffd", bus.lo); end
    n_tests++; if (bus.hi !== 32'd1)         begin n_fail++; $display("FAIL div_negb_hi got %h want 00000001", bus.hi); end
    run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dz);
    n_tests++; if (bus.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_min_lo got %h want 80000000", bus.lo); end
    n_tests++; if (bus.hi !== 32'd0)         begin n_fail++; $display("FAIL div_min_hi got %h want 0", bus.hi); end
  endtask

  task automatic test_div_zero;
    int cyc, dz;
    run_md(F_DIVU, 32'd5, 32'd0, cyc, dz);
    n_tests++; if (cyc !== 33)              begin n_fail++; $display("FAIL dz_busy_cycles got %0d want 33", cyc); end
    n_tests++; if (dz !== 1)                begin n_fail++; $display("FAIL dz_pulse_cycles got %0d want 1", dz); end
    n_tests++; if (bus.hi !== 32'd5)         begin n_fail++; $display("FAIL dz_hi got %h want 00000005", bus.hi); end
    n_tests++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_lo got %h want ffffffff", bus.lo); end
    n_tests++; if (bus.div_zero !== 1'b0)    begin n_fail++; $display("FAIL dz_after got %0b want 0", bus.div_zero); end
    run_md(F_DIV, 32'hFFFF_FFF8, 32'd0, cyc, dz);
    n_tests++; if (dz !== 1)                 begin n_fail++; $display("FAIL dz_signed_pulse got %0d want 1", dz); end
    n_tests++; if (bus.hi !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL dz_signed_hi got %h want fffffff8", bus.hi); end
    n_tests++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_signed_lo got %h want ffffffff", bus.lo); end
  endtask

  task automatic test_mf_stall;
    int n;
    @(negedge clk);
    drive(ALUOP_RTYPE, F_MULTU, 1'b1, 32'd6, 32'd7);
    @(negedge clk);
    drive(ALUOP_RTYPE, F_ADD, 1'b1, 32'd0, 32'd0);
    #1;
    n_tests++; if (bus.stall !== 1'b0)    begin n_fail++; $display("FAIL add_no_stall got %0b want 0", bus.stall); end
    n_tests++; if (bus.alu_func !== 4'b0111) begin n_fail++; $display("FAIL add_busy_func got %b want 0111", bus.alu_func); end
    n_tests++; if (bus.busy !== 1'b1)     begin n_fail++; $display("FAIL mf_engine_busy got %0b want 1", bus.busy); end
    @(negedge clk);
    drive(ALUOP_RTYPE, F_MFLO, 1'b1, 32'd0, 32'd0);
    #1;
    n_tests++; if (bus.stall !== 1'b1)    begin n_fail++; $display("FAIL mflo_stall got %0b want 1", bus.stall); end
    n_tests++; if (bus.mf_valid !== 1'b0) begin n_fail++; $display("FAIL mflo_early_valid got %0b want 0", bus.mf_valid); end
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    n_tests++; if (n !== 32)              begin n_fail++; $display("FAIL mflo_stall_cycles got %0d want 32", n); end
    n_tests++; if (bus.mf_valid !== 1'b1) begin n_fail++; $display("FAIL mflo_valid got %0b want 1", bus.mf_valid); end
    n_tests++; if (bus.mf_result !== 32'd42) begin n_fail++; $display("FAIL mflo_result got %h want 0000002a", bus.mf_result); end
    drive(ALUOP_RTYPE, F_MFHI, 1'b1, 32'd0, 32'd0);
    #1;
    n_tests++; if (bus.mf_result !== 32'd0) begin n_fail++; $display("FAIL mfhi_result got %h want 0", bus.mf_result); end
    @(negedge clk);
    drive(ALUOP_LSW, 6'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_back_to_back;
    int n, cyc;
    @(negedge clk);
    drive(ALUOP_RTYPE, F_DIVU, 1'b1, 32'd100, 32'd7);
    @(negedge clk);
    drive(ALUOP_RTYPE, F_MULTU, 1'b1, 32'd3, 32'd5);
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_tests++; if (n !== 33)            begin n_fail++; $display("FAIL b2b_stall_cycles got %0d want 33", n); end
    n_tests++; if (bus.lo !== 32'd14)   begin n_fail++; $display("FAIL b2b_first_lo got %h want 0000000e", bus.lo); end
    n_tests++; if (bus.hi !== 32'd2)    begin n_fail++; $display("FAIL b2b_first_hi got %h want 00000002", bus.hi); end
    @(negedge clk);
    drive(ALUOP_LSW, 6'd0, 1'b0, 32'd0, 32'd0);
    n_tests++; if (bus.busy !== 1'b1)   begin n_fail++; $display("FAIL b2b_accept got busy %0b want 1", bus.busy); end
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++; if (bus.lo !== 32'd15)   begin n_fail++; $display("FAIL b2b_second_lo got %h want 0000000f", bus.lo); end
    n_tests++; if (bus.hi !== 32'd0)    begin n_fail++; $display("FAIL b2b_second_hi got %h want 0", bus.hi); end
  endtask

  task automatic test_reset_mid_op;
    int cyc, dz;
    @(negedge clk);
    drive(ALUOP_RTYPE, F_MULT, 1'b1, 32'd5, 32'd6);
    @(negedge clk);
    drive(ALUOP_LSW, 6'd0, 1'b0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL abort_busy got %0b want 0", bus.busy); end
    n_tests++; if (bus.hi !== 32'd0)      begin n_fail++; $display("FAIL abort_hi got %h want 0", bus.hi); end
    n_tests++; if (bus.lo !== 32'd0)      begin n_fail++; $display("FAIL abort_lo got %h want 0", bus.lo); end
    n_tests++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL abort_dz got %0b want 0", bus.div_zero); end
    reset = 1'b0;
    run_md(F_MULTU, 32'd3, 32'd4, cyc, dz);
    n_tests++; if (cyc !== 33)          begin n_fail++; $display("FAIL post_reset_cycles got %0d want 33", cyc); end
    n_tests++; if (bus.lo !== 32'd12)   begin n_fail++; $display("FAIL post_reset_lo got %h want 0000000c", bus.lo); end
    n_tests++; if (bus.hi !== 32'd0)    begin n_fail++; $display("FAIL post_reset_hi got %h want 0", bus.hi); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_mult;
    test_div;
    test_div_zero;
    test_mf_stall;
    test_back_to_back;
    test_reset_mid_op;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
